serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
Downstream consumer of the team's serial shift-register chain. It takes the delayed serial bit stream, one bit per clk, and finds framed words: a start bit, DATA_WIDTH data bits LSB first, an optional even-parity bit and a stop bit. It deserializes each frame into a parallel word and presents it through a one-entry valid/ready output buffer, with error and overrun flags.

Parameters:
DATA_WIDTH, 4, number of data bits per frame (legal range 1..16)
PARITY_EN, 0, 1 = an even-parity bit follows the data bits; 0 = no parity bit

Ports:
clk  input  1  system clock; every bit is sampled on posedge
rst  input  1  asynchronous, active-high reset
ip  input  1  serial line in; idle level 1
data_out  output  DATA_WIDTH  received word, held stable while data_valid=1
data_valid  output  1  output buffer holds an unconsumed word
data_ready  input  1  consumer accepts data_out on a posedge where data_valid=1
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
parity_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only)
overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- While rst=1, immediately: state=IDLE, data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, shift register and bit counter cleared.
- Reset mid-frame aborts the partial frame and clears the buffered word; nothing is emitted.
- Sampling: one bit per posedge; no oversampling.
- State machine, states IDLE, DATA, PARITY, STOP, BREAK:
  - IDLE: ip=0 is the start bit; go to DATA with bit counter=0. ip=1 stays in IDLE.
  - DATA: shift ip into bit[counter], LSB first, and increment the counter. After DATA_WIDTH bits go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: the sampled bit must equal the XOR of the data bits (even parity). Record mismatch; go to STOP.
  - STOP, ip=1, parity OK: frame is good; go to IDLE.
  - STOP, ip=1, parity bad: parity_err pulses in the next cycle; word discarded; go to IDLE.
  - STOP, ip=0: frame_err pulses in the next cycle; word discarded; go to BREAK. Parity is not reported in this case.
  - BREAK: wait for ip=1, then go to IDLE. A low line is never taken as a new start bit until the line has returned to 1.
- Back-to-back frames: a start bit may arrive in the cycle right after the stop bit (IDLE sees it at once).
- Latency: start bit sampled at edge 0. Stop bit sampled at edge DATA_WIDTH+1+PARITY_EN. data_valid=1 and data_out are updated after that same edge, so they are visible in the following cycle.
- Output buffer:
  - A good frame loads data_out and sets data_valid if the buffer is empty, or if data_ready=1 on that same edge (simultaneous consume and load: no overrun).
  - If the buffer is full and data_ready=0, the new word is dropped, overrun pulses for one cycle, and the old data_out is kept.
  - data_valid clears on the edge where data_valid=1 and data_ready=1 with no new load.
  - data_out never changes while data_valid=1 unless the buffered word is consumed on that edge.
- Error pulses are exactly one cycle wide and mutually exclusive per frame.

Test Plan:
- DATA_WIDTH=4, PARITY_EN=0, data_ready=1; ip = 1,1,0,1,0,1,1,1 -> after the stop-bit edge, data_valid=1 for 1 cycle with data_out=4'hD; no error pulses.
- Two back-to-back frames 0x3 then 0xA, data_ready=0 -> first word held with data_valid=1 and data_out=4'h3; second frame gives overrun=1 for 1 cycle and data_out stays 4'h3. Raise data_ready -> data_valid falls the next cycle.
- Stop bit sent as 0, then ip held 0 for 5 cycles, then 1 -> frame_err=1 for 1 cycle; no data_valid; no false start during the low period. A following good frame 0x5 is received correctly.
- PARITY_EN=1; frame 0x7 with parity bit 1 -> data_out=4'h7. Same frame with parity bit 0 -> parity_err pulse; data_valid stays 0.
- Simultaneous events: buffer full and data_ready=1 on the same edge a good frame 0x9 completes -> data_valid stays 1, data_out=4'h9, overrun=0.
- Assert rst in the middle of the DATA bits, release, then send frame 0x2 -> all outputs 0 during reset; the partial frame is never emitted; 0x2 is received cleanly.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bit.
// Good words land in a one-entry valid/ready buffer; framing, parity and overrun errors pulse for one cycle.
module serial_frame_receiver #(
  parameter int DATA_WIDTH = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ip,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);

  // state  | meaning
  // IDLE   | line idle, waiting for a 0 start bit
  // DATA   | shifting data bits in, LSB first
  // PARITY | sampling the even-parity bit
  // STOP   | sampling the stop bit, frame verdict
  // BREAK  | line held low after a bad stop bit, wait for 1
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  localparam int CW = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_par_bad;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_frame_err;
  logic                  r_parity_err;
  logic                  r_overrun;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  w_par_bad_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_ferr_nxt;
  logic                  w_perr_nxt;
  logic                  w_ovr_nxt;
  logic                  w_good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_par_bad    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_par_bad    <= w_par_bad_nxt;
      r_data_out   <= w_data_nxt;
      r_data_valid <= w_valid_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_parity_err <= w_perr_nxt;
      r_overrun    <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_par_bad_nxt = r_par_bad;
    w_data_nxt    = r_data_out;
    w_valid_nxt   = r_data_valid;
    w_ferr_nxt    = 1'b0;
    w_perr_nxt    = 1'b0;
    w_ovr_nxt     = 1'b0;
    w_good        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!ip) begin
          w_state_nxt   = DATA;
          w_cnt_nxt     = '0;
          w_shift_nxt   = '0;
          w_par_bad_nxt = 1'b0;
        end
      end
      DATA: begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (r_cnt == CW'(i)) w_shift_nxt[i] = ip;
        end
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_BIT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        // every data bit is already in the shift register here
        w_par_bad_nxt = ip ^ (^r_shift);
        w_state_nxt   = STOP;
      end
      STOP: begin
        if (!ip) begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = BREAK;
        end else begin
          w_state_nxt = IDLE;
          if (r_par_bad) w_perr_nxt = 1'b1;
          else           w_good     = 1'b1;
        end
      end
      BREAK: begin
        if (ip) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // a consume on the same edge frees the buffer for the incoming word
    if (w_good) begin
      if (!r_data_valid || data_ready) begin
        w_data_nxt  = r_shift;
        w_valid_nxt = 1'b1;
      end else begin
        w_ovr_nxt = 1'b1;
      end
    end else if (r_data_valid && data_ready) begin
      w_valid_nxt = 1'b0;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: instance 0 without parity, instance 1 with even parity.
// A frame-level model predicts the buffer and pulses; literal checks pin known frames.
module tb_serial_frame_receiver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] ip_v = 2'b11;
  logic [1:0] rdy_v = 2'b00;
  logic [3:0] dout_v [2];
  logic [1:0] val_v, ferr_v, perr_v, ovr_v;

  serial_frame_receiver #(.DATA_WIDTH(4), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .ip(ip_v[0]),
    .data_out(dout_v[0]), .data_valid(val_v[0]), .data_ready(rdy_v[0]),
    .frame_err(ferr_v[0]), .parity_err(perr_v[0]), .overrun(ovr_v[0])
  );

  serial_frame_receiver #(.DATA_WIDTH(4), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .ip(ip_v[1]),
    .data_out(dout_v[1]), .data_valid(val_v[1]), .data_ready(rdy_v[1]),
    .frame_err(ferr_v[1]), .parity_err(perr_v[1]), .overrun(ovr_v[1])
  );

  int total = 0;
  int bad = 0;

  logic [1:0] m_valid = '0, m_ferr = '0, m_perr = '0, m_ovr = '0;
  logic [3:0] m_data [2] = '{4'h0, 4'h0};

  // per-edge frame descriptor: set by the driver only on the stop-bit cycle
  logic [1:0] t_stop = '0, t_sbit = '0, t_pok = '0;
  logic [3:0] t_word [2] = '{4'h0, 4'h0};

  logic       n_rst = 1'b1;
  logic [1:0] n_ip  = 2'b11;
  logic [1:0] n_rdy = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame verdict from the descriptor, then the one-entry buffer rules
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_ferr[d] = 1'b0;
      m_perr[d] = 1'b0;
      m_ovr[d]  = 1'b0;
      if (rst) begin
        m_valid[d] = 1'b0;
        m_data[d]  = 4'h0;
      end else if (t_stop[d] && !t_sbit[d]) begin
        m_ferr[d] = 1'b1;
      end else if (t_stop[d] && !t_pok[d]) begin
        m_perr[d] = 1'b1;
      end else if (t_stop[d]) begin
        if (!m_valid[d] || rdy_v[d]) begin
          m_valid[d] = 1'b1;
          m_data[d]  = t_word[d];
        end else begin
          m_ovr[d] = 1'b1;
        end
      end else if (m_valid[d] && rdy_v[d]) begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("valid%0d", d), val_v[d], m_valid[d]);
      check($sformatf("frame_err%0d", d), ferr_v[d], m_ferr[d]);
      check($sformatf("parity_err%0d", d), perr_v[d], m_perr[d]);
      check($sformatf("overrun%0d", d), ovr_v[d], m_ovr[d]);
      if (m_valid[d] || rst)
        check($sformatf("data%0d", d), dout_v[d], m_data[d]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    rst   = n_rst;
    ip_v  = n_ip;
    rdy_v = n_rdy;
    @(posedge clk);
    #1;
    model_edge();
    t_stop = '0;
  endtask

  task automatic idle(input int n);
    n_ip = 2'b11;
    repeat (n) tick();
  endtask

  // srdy >= 0 overrides data_ready of instance d for the stop-bit cycle only
  task automatic send_frame(input int d, input logic [3:0] w, input logic pbit,
                            input logic sbit, input int srdy);
    logic [1:0] keep;
    n_ip    = 2'b11;
    n_ip[d] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_ip[d] = w[i];
      tick();
    end
    if (d == 1) begin
      n_ip[d] = pbit;
      tick();
    end
    keep = n_rdy;
    if (srdy >= 0) n_rdy[d] = srdy[0];
    n_ip[d]   = sbit;
    t_stop[d] = 1'b1;
    t_sbit[d] = sbit;
    t_word[d] = w;
    t_pok[d]  = (d == 0) || (pbit == ^w);
    tick();
    n_rdy = keep;
    n_ip  = 2'b11;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid0", val_v[0], 1'b0);
    check("rst_data0", dout_v[0], 4'h0);
    n_rst = 1'b0;
    idle(2);

    // 1,1,0,1,0,1,1,1 -> 0xD
    n_rdy = 2'b01;
    idle(2);
    send_frame(0, 4'hD, 1'b0, 1'b1, -1);
    check("t1_valid", val_v[0], 1'b1);
    check("t1_data", dout_v[0], 4'hD);
    check("t1_ferr", ferr_v[0], 1'b0);
    idle(1);
    check("t1_valid_drop", val_v[0], 1'b0);

    // back-to-back with a full buffer
    n_rdy = 2'b00;
    send_frame(0, 4'h3, 1'b0, 1'b1, -1);
    check("t2_valid", val_v[0], 1'b1);
    check("t2_data_first", dout_v[0], 4'h3);
    send_frame(0, 4'hA, 1'b0, 1'b1, -1);
    check("t2_overrun", ovr_v[0], 1'b1);
    check("t2_data_kept", dout_v[0], 4'h3);
    idle(1);
    check("t2_overrun_pulse", ovr_v[0], 1'b0);
    n_rdy[0] = 1'b1;
    idle(1);
    check("t2_consumed", val_v[0], 1'b0);

    // stop bit low, line held low, then a good frame
    send_frame(0, 4'h6, 1'b0, 1'b0, -1);
    check("t3_ferr", ferr_v[0], 1'b1);
    check("t3_no_valid", val_v[0], 1'b0);
    n_ip = 2'b10;
    repeat (5) tick();
    check("t3_ferr_pulse", ferr_v[0], 1'b0);
    idle(1);
    send_frame(0, 4'h5, 1'b0, 1'b1, -1);
    check("t3_data", dout_v[0], 4'h5);
    check("t3_valid", val_v[0], 1'b1);

    // even parity on instance 1
    n_rdy[1] = 1'b1;
    idle(2);
    send_frame(1, 4'h7, 1'b1, 1'b1, -1);
    check("t4_valid", val_v[1], 1'b1);
    check("t4_data", dout_v[1], 4'h7);
    idle(1);
    send_frame(1, 4'h7, 1'b0, 1'b1, -1);
    check("t4_perr", perr_v[1], 1'b1);
    check("t4_no_valid", val_v[1], 1'b0);
    idle(1);
    check("t4_perr_pulse", perr_v[1], 1'b0);

    // consume and load on the same edge
    n_rdy = 2'b00;
    send_frame(0, 4'h1, 1'b0, 1'b1, -1);
    check("t5_full", val_v[0], 1'b1);
    send_frame(0, 4'h9, 1'b0, 1'b1, 1);
    check("t5_valid", val_v[0], 1'b1);
    check("t5_data", dout_v[0], 4'h9);
    check("t5_no_overrun", ovr_v[0], 1'b0);
    idle(1);
    check("t5_held", dout_v[0], 4'h9);
    n_rdy[0] = 1'b1;
    idle(1);
    check("t5_consumed", val_v[0], 1'b0);

    // reset mid-frame with a word buffered
    n_rdy = 2'b00;
    send_frame(0, 4'hE, 1'b0, 1'b1, -1);
    check("t6_prefill", val_v[0], 1'b1);
    n_ip = 2'b10;
    tick();
    n_ip[0] = 1'b1;
    tick();
    n_ip[0] = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("t6_rst_valid", val_v[0], 1'b0);
    check("t6_rst_data", dout_v[0], 4'h0);
    tick();
    n_rst = 1'b0;
    n_rdy[0] = 1'b1;
    idle(3);
    check("t6_no_partial", val_v[0], 1'b0);
    send_frame(0, 4'h2, 1'b0, 1'b1, -1);
    check("t6_data", dout_v[0], 4'h2);
    check("t6_valid", val_v[0], 1'b1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
